elevador_scan_ctrl: RTL and testbench

Parametrised successor to the fixed 4-floor, 2-bit floor-state machine. It drives a single car over NUM_FLOORS floors and latches every button request until the car serves it. Floor selection follows SCAN: the car keeps its direction while requests remain ahead. Per-floor travel time and a door-open dwell are timed by counters. The erro input freezes the block without losing state, and the block sits directly behind the button/sensor input stage.

---
 rtl/elevador_pkg.sv | 31 +++
 rtl/elevador_req_reg.sv | 47 ++++
 rtl/elevador_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_elevador_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
// Optional feature macro used by the top: ELEV_DOOR_HOLD_EN.
package elevador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Upper bound on floors supported by the mask helper.
  localparam int unsigned MAX_FLOORS = 32;

  // Keeps only the pending bits strictly beyond flr in the given direction.
  function automatic logic [MAX_FLOORS-1:0] dir_mask(
    input logic [MAX_FLOORS-1:0] pend,
    input int unsigned           flr,
    input logic                  up
  );
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
      if (up ? (i > flr) : (i < flr)) m[i] = pend[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/elevador_req_reg.sv
// Latched floor requests with per-floor clear, plus ahead/behind summaries
// evaluated at a selectable floor.
module elevador_req_reg
  import elevador_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 4,
  parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  clr_en,
  input  logic [FLOOR_W-1:0]    sel_floor,
  input  logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  sel_pend,
  output logic                  ahead,
  output logic                  behind
);

  logic [NUM_FLOORS-1:0] pend_q;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [MAX_FLOORS-1:0] pend_ext;
  logic [MAX_FLOORS-1:0] ahead_m;
  logic [MAX_FLOORS-1:0] behind_m;

  always_comb begin
    clr_mask = '0;
    if (clr_en) clr_mask[sel_floor] = 1'b1;
  end

  // A new request and a clear on the same floor in the same cycle: clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= (pend_q | req) & ~clr_mask;
  end

  assign pend_ext = MAX_FLOORS'(pend_q);
  assign ahead_m  = dir_mask(pend_ext, 32'(sel_floor), dir_up);
  assign behind_m = dir_mask(pend_ext, 32'(sel_floor), ~dir_up);

  assign ahead    = |ahead_m;
  assign behind   = |behind_m;
  assign sel_pend = pend_q[sel_floor];
  assign pending  = pend_q;

endmodule

// File: rtl/elevador_scan_ctrl.sv
// Single-car SCAN elevator controller with travel and door-dwell timers.
// Define ELEV_DOOR_HOLD_EN to add the door_hold input that keeps the door open.
module elevador_scan_ctrl
  import elevador_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = 4,
  parameter int unsigned FLOOR_W     = $clog2(NUM_FLOORS),
  parameter int unsigned MOVE_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  erro,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  arrived
`ifdef ELEV_DOOR_HOLD_EN
  ,
  input  logic                  door_hold
`endif
);

  localparam int unsigned MC_W = $clog2(MOVE_CYCLES + 1);
  localparam int unsigned DC_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [MC_W-1:0]    MOVE_LAST = MC_W'(MOVE_CYCLES - 1);
  localparam logic [DC_W-1:0]    DOOR_LOAD = DC_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  state_t             state_q, state_n;
  logic [FLOOR_W-1:0] floor_q, floor_n;
  logic [FLOOR_W-1:0] step_floor, sel_floor;
  logic               dir_q, dir_n;
  logic [MC_W-1:0]    move_q, move_n;
  logic [DC_W-1:0]    door_q, door_n;
  logic               arr_q, arr_n;
  logic               arrive, hold_req, clr_en;
  logic               ahead, behind, sel_pend;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold_req = door_hold;
`else
  assign hold_req = 1'b0;
`endif

  assign arrive = (state_q == MOVE) && (move_q == MOVE_LAST);

  always_comb begin
    step_floor = floor_q;
    if (dir_q == DIR_UP) begin
      if (floor_q != TOP_FLOOR) step_floor = floor_q + 1'b1;
    end else begin
      if (floor_q != '0) step_floor = floor_q - 1'b1;
    end
  end

  // On the arrival cycle the request logic already looks at the new floor, so
  // the stop/continue decision and the clear happen on the same edge.
  assign sel_floor = arrive ? step_floor : floor_q;
  assign clr_en    = ~erro & ((state_q == DOOR) | (state_n == DOOR));

  elevador_req_reg #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_req (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .clr_en    (clr_en),
    .sel_floor (sel_floor),
    .dir_up    (dir_q),
    .pending   (pending),
    .sel_pend  (sel_pend),
    .ahead     (ahead),
    .behind    (behind)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      floor_q <= '0;
      dir_q   <= DIR_UP;
      move_q  <= '0;
      door_q  <= '0;
      arr_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      floor_q <= floor_n;
      dir_q   <= dir_n;
      move_q  <= move_n;
      door_q  <= door_n;
      arr_q   <= arr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    floor_n = floor_q;
    dir_n   = dir_q;
    move_n  = move_q;
    door_n  = door_q;
    arr_n   = arr_q;
    if (!erro) begin
      arr_n = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sel_pend) begin
            state_n = DOOR;
            door_n  = DOOR_LOAD;
          end else if (ahead) begin
            state_n = MOVE;
            move_n  = '0;
          end else if (behind) begin
            state_n = MOVE;
            move_n  = '0;
            dir_n   = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
          end
        end
        MOVE: begin
          if (arrive) begin
            floor_n = step_floor;
            arr_n   = 1'b1;
            move_n  = '0;
            if (sel_pend) begin
              state_n = DOOR;
              door_n  = DOOR_LOAD;
            end else if (!ahead) begin
              state_n = IDLE;
            end
          end else begin
            move_n = move_q + 1'b1;
          end
        end
        DOOR: begin
          if (req[floor_q] || hold_req) begin
            door_n = DOOR_LOAD;
          end else if (door_q == '0) begin
            state_n = IDLE;
          end else begin
            door_n = door_q - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign floor     = floor_q;
  assign dir_up    = dir_q;
  assign moving    = (state_q == MOVE);
  assign door_open = (state_q == DOOR);
  assign arrived   = arr_q;

endmodule

// File: tb/tb_elevador_scan_ctrl.sv
// Self-checking bench: directed scenarios plus randomized requests/faults,
// compared every cycle against a behavioural SCAN model.
module tb_elevador_scan_ctrl;

  localparam int NF = 4;
  localparam int MC = 4;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] req;
  logic          erro;
  logic [1:0]    floor;
  logic          dir_up, moving, door_open, arrived;
  logic [NF-1:0] pending;
`ifdef ELEV_DOOR_HOLD_EN
  logic          door_hold;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  elevador_scan_ctrl #(
    .NUM_FLOORS  (NF),
    .FLOOR_W     (2),
    .MOVE_CYCLES (MC),
    .DOOR_CYCLES (DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .erro      (erro),
    .floor     (floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending),
    .arrived   (arrived)
`ifdef ELEV_DOOR_HOLD_EN
    ,
    .door_hold (door_hold)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = resting, 1 = travelling, 2 = door open
  int m_floor, m_mode, m_travel_left, m_door_left;
  bit m_up, m_arr;
  bit m_pend[NF];
  bit snap[NF];

  function automatic bit beyond(int f, bit up);
    for (int i = 0; i < NF; i++)
      if (snap[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_floor = 0; m_mode = 0; m_travel_left = 0; m_door_left = 0;
    m_up = 1'b1; m_arr = 1'b0;
    for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
  endtask

  task automatic m_step(input logic [NF-1:0] r, input bit e, input bit h);
    snap = m_pend;
    for (int i = 0; i < NF; i++) m_pend[i] = m_pend[i] | r[i];
    if (e) return;
    m_arr = 1'b0;
    case (m_mode)
      0: begin
        if (snap[m_floor]) begin
          m_mode = 2; m_door_left = DC; m_pend[m_floor] = 1'b0;
        end else if (beyond(m_floor, m_up)) begin
          m_mode = 1; m_travel_left = MC;
        end else if (beyond(m_floor, !m_up)) begin
          m_up = !m_up; m_mode = 1; m_travel_left = MC;
        end
      end
      1: begin
        m_travel_left--;
        if (m_travel_left == 0) begin
          m_floor = m_up ? m_floor + 1 : m_floor - 1;
          m_arr = 1'b1;
          if (snap[m_floor]) begin
            m_mode = 2; m_door_left = DC; m_pend[m_floor] = 1'b0;
          end else if (beyond(m_floor, m_up)) m_travel_left = MC;
          else m_mode = 0;
        end
      end
      default: begin
        m_pend[m_floor] = 1'b0;
        if (r[m_floor] || h) m_door_left = DC;
        else if (m_door_left == 1) m_mode = 0;
        else m_door_left--;
      end
    endcase
  endtask

  function automatic int pend_int();
    int v = 0;
    for (int i = 0; i < NF; i++) if (m_pend[i]) v |= (1 << i);
    return v;
  endfunction

  initial m_reset();

  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else begin
`ifdef ELEV_DOOR_HOLD_EN
      m_step(req, erro, door_hold);
`else
      m_step(req, erro, 1'b0);
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("floor",     int'(floor),     m_floor);
      chk("dir_up",    int'(dir_up),    int'(m_up));
      chk("moving",    int'(moving),    int'(m_mode == 1));
      chk("door_open", int'(door_open), int'(m_mode == 2));
      chk("pending",   int'(pending),   pend_int());
      chk("arrived",   int'(arrived),   int'(m_arr));
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_arrive(output int n);
    n = 0;
    do begin step(); n++; end while (!arrived && n < 40);
  endtask

  task automatic wait_door(output int f, output int d);
    int b = 0;
    while (door_open && b < 100) begin step(); b++; end
    while (!door_open && b < 300) begin step(); b++; end
    chk("wait_door_timeout", int'(door_open), 1);
    f = int'(floor);
    d = int'(dir_up);
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((moving || door_open || pending != '0) && b < 400) begin step(); b++; end
    chk("wait_idle_timeout", int'(moving || door_open || pending != '0), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_floor"},   int'(floor),     0);
    chk({tag, "_dir"},     int'(dir_up),    1);
    chk({tag, "_moving"},  int'(moving),    0);
    chk({tag, "_door"},    int'(door_open), 0);
    chk({tag, "_pending"}, int'(pending),   0);
    chk({tag, "_arrived"}, int'(arrived),   0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, f, d;
    reset = 1'b1; req = '0; erro = 1'b0;
`ifdef ELEV_DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    check_reset_vals("rst");

    // Request at the idle car's floor: latch, then door, open for DC cycles.
    req = 4'b0001; step();
    chk("a_latched", int'(pending), 1);
    chk("a_door_early", int'(door_open), 0);
    req = '0; step();
    chk("a_door_open", int'(door_open), 1);
    chk("a_pending_clr", int'(pending), 0);
    n = 1;
    while (door_open && n < 50) begin step(); if (door_open) n++; end
    chk("a_door_len", n, DC);
    step();
    chk("a_idle", int'(moving || door_open), 0);

    // Travel 0 -> 3 in floor steps of MC cycles.
    req = 4'b1000; step(); req = '0; step();
    chk("b_moving", int'(moving), 1);
    for (int k = 1; k <= 3; k++) begin
      wait_arrive(n);
      chk("b_step_cycles", n, MC);
      chk("b_floor", int'(floor), k);
    end
    chk("b_door_top", int'(door_open), 1);
    chk("b_dir_top", int'(dir_up), 1);
    wait_idle();

    // Return to 0, then at floor 2 going up request 0 and 3.
    req = 4'b0001; step(); req = '0;
    wait_idle();
    chk("c_floor0", int'(floor), 0);
    chk("c_dir_down", int'(dir_up), 0);
    req = 4'b1000; step(); req = '0;
    n = 0;
    do begin step(); n++; end while (!(arrived && floor == 2'd2) && n < 100);
    chk("c_at2", int'(floor), 2);
    req = 4'b1001; step(); req = '0;
    wait_door(f, d);
    chk("c_first_floor", f, 3);
    chk("c_first_dir", d, 1);
    wait_door(f, d);
    chk("c_second_floor", f, 0);
    chk("c_second_dir", d, 0);
    wait_idle();

    // Fault freeze mid-travel with a new request arriving meanwhile.
    req = 4'b1000; step(); req = '0; step();
    chk("d_moving", int'(moving), 1);
    step(); step();
    erro = 1'b1; req = 4'b0010;
    repeat (10) step();
    chk("d_frozen_floor", int'(floor), 0);
    chk("d_frozen_moving", int'(moving), 1);
    chk("d_pend1", int'(pending[1]), 1);
    erro = 1'b0; req = '0;
    wait_arrive(n);
    chk("d_remaining", n, 2);
    chk("d_floor1", int'(floor), 1);
    chk("d_door1", int'(door_open), 1);
    wait_idle();

    // Asynchronous reset while the door is open at floor 2.
    req = 4'b0100; step(); req = '0;
    wait_door(f, d);
    chk("e_floor2", f, 2);
    step(); step();
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    @(posedge clk); #1 reset = 1'b0;

`ifdef ELEV_DOOR_HOLD_EN
    // Door hold keeps the door open; it then closes DC cycles after release.
    req = 4'b0001; step(); req = '0;
    wait_door(f, d);
    n = 1;
    door_hold = 1'b1;
    repeat (20) begin step(); if (door_open) n++; end
    door_hold = 1'b0;
    while (door_open && n < 100) begin step(); if (door_open) n++; end
    chk("f_hold_len", n, 20 + DC);
`endif

    // Random traffic with sporadic faults.
    for (int c = 0; c < 2500; c++) begin
      req = ($urandom_range(0, 7) == 0) ? NF'($urandom_range(1, 15)) : '0;
      if (erro) erro = ($urandom_range(0, 3) != 0);
      else      erro = ($urandom_range(0, 39) == 0);
`ifdef ELEV_DOOR_HOLD_EN
      door_hold = ($urandom_range(0, 9) == 0);
`endif
      step();
    end
    req = '0; erro = 1'b0;
`ifdef ELEV_DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
    wait_idle();
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
